keypad_scanner: RTL and testbench



---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_debounce.sv | 122 ++++++++++++
 rtl/keypad_scanner.sv | 105 ++++++++++
 tb/tb_keypad_scanner.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: debounce states, matrix
// geometry, idle row drive and well-known key codes.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CHK,
    ACCEPT,
    HELD,
    RELEASE_CHK
  } deb_state_t;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  localparam logic [3:0] KEY_START = 4'd15;
  localparam logic [3:0] KEY_MENU  = 4'd12;

  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM: a press or a release is accepted only after
// DEBOUNCE_FRAMES consecutive agreeing scan frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       frame_tick,
  input  logic       raw_pressed,
  input  logic [3:0] raw_code,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_FRAMES);

  deb_state_t    state_reg, state_next;
  logic [3:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          key_valid_reg, key_valid_next;
  logic [3:0]    key_code_reg, key_code_next;
  logic          key_held_reg, key_held_next;
  logic          match;

  assign match = raw_pressed && (raw_code == cand_reg);

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    key_valid_next = 1'b0;
    key_code_next  = key_code_reg;
    key_held_next  = key_held_reg;
    case (state_reg)
      IDLE: begin
        if (frame_tick && raw_pressed) begin
          cand_next  = raw_code;
          cnt_next   = CNT_ONE;
          state_next = (DEBOUNCE_FRAMES == 1) ? ACCEPT : PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (frame_tick) begin
          if (match) begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_next == CNT_DONE) state_next = ACCEPT;
          end else begin
            cnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      ACCEPT: state_next = HELD;
      HELD: begin
        if (frame_tick && !match) begin
          cnt_next = CNT_ONE;
          if (DEBOUNCE_FRAMES == 1) begin
            key_held_next = 1'b0;
            state_next    = IDLE;
          end else begin
            state_next = RELEASE_CHK;
          end
        end
      end
      RELEASE_CHK: begin
        if (frame_tick) begin
          if (match) begin
            state_next = HELD;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
            if (cnt_next == CNT_DONE) begin
              key_held_next = 1'b0;
              state_next    = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // ACCEPT is only ever entered, never re-entered, so this fires exactly once per press.
    if (state_next == ACCEPT) begin
      key_valid_next = 1'b1;
      key_code_next  = cand_next;
      key_held_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= '0;
      key_held_reg  <= 1'b0;
    end else if (clear) begin
      state_reg     <= IDLE;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      key_held_reg  <= key_held_next;
    end
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign key_held  = key_held_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the active-low rows, samples synchronized
// columns at the end of each dwell, and feeds per-frame results to the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 250000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic          active_reg;
  logic [DW-1:0] dwell_reg, dwell_next;
  logic [1:0]    row_idx_reg, row_idx_next;
  logic [3:0]    row_reg;
  logic [3:0]    col_meta_reg, col_sync_reg;
  logic          acc_pressed_reg;
  logic [3:0]    acc_code_reg;

  logic       sample_point, frame_tick;
  logic       row_hit;
  logic [1:0] hit_col;
  logic [3:0] row_code;
  logic       raw_pressed;
  logic [3:0] raw_code;

  assign sample_point = active_reg && (dwell_reg == DWELL_LAST);
  assign frame_tick   = sample_point && (row_idx_reg == 2'(KEY_ROWS - 1));
  assign dwell_next   = (dwell_reg == DWELL_LAST) ? '0 : dwell_reg + DW'(1);
  assign row_idx_next = (dwell_reg == DWELL_LAST) ? row_idx_reg + 2'd1 : row_idx_reg;

  // Scan high-to-low so the lowest pressed column is the one left standing.
  always_comb begin
    row_hit = 1'b0;
    hit_col = '0;
    for (int c = KEY_COLS - 1; c >= 0; c--) begin
      if (!col_sync_reg[c]) begin
        row_hit = 1'b1;
        hit_col = 2'(c);
      end
    end
  end

  assign row_code    = key_code_of(row_idx_reg, hit_col);
  assign raw_pressed = acc_pressed_reg || row_hit;
  assign raw_code    = acc_pressed_reg ? acc_code_reg : row_code;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      active_reg      <= 1'b0;
      dwell_reg       <= '0;
      row_idx_reg     <= '0;
      row_reg         <= ROW_IDLE;
      col_meta_reg    <= 4'b1111;
      col_sync_reg    <= 4'b1111;
      acc_pressed_reg <= 1'b0;
      acc_code_reg    <= '0;
    end else begin
      active_reg   <= 1'b1;
      col_meta_reg <= keypadCol;
      col_sync_reg <= col_meta_reg;
      if (active_reg) begin
        dwell_reg   <= dwell_next;
        row_idx_reg <= row_idx_next;
        row_reg     <= ~(4'b0001 << row_idx_next);
        if (frame_tick) begin
          acc_pressed_reg <= 1'b0;
          acc_code_reg    <= '0;
        end else if (sample_point && row_hit && !acc_pressed_reg) begin
          acc_pressed_reg <= 1'b1;
          acc_code_reg    <= row_code;
        end
      end else begin
        row_reg <= 4'b1110;
      end
    end
  end

  assign keypadRow = row_reg;

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .clear      (!enable),
    .frame_tick (frame_tick),
    .raw_pressed(raw_pressed),
    .raw_code   (raw_code),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_held   (key_held)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (16-cycle frames).
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] keypadCol;
  logic [3:0] keypadRow;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] keys;
  int tests_run;
  int tests_failed;
  int pulses;
  int p0;
  logic prev_valid;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .keypadCol(keypadCol),
    .keypadRow(keypadRow),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key shorts its column to the row currently driven low.
  always_comb begin
    keypadCol = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && keypadRow[r] === 1'b0) keypadCol[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
      check("valid_not_back_to_back", int'(prev_valid), 0);
    end
    prev_valid = key_valid;
  endtask

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          frames;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
  } step_t;

  step_t steps[7];

  initial begin
    logic [3:0] exp_row;

    steps[0] = '{"bounce_press1",  16'h0080, 2, 0, 4'd9,  1'b0};
    steps[1] = '{"bounce_gap",     16'h0000, 1, 0, 4'd9,  1'b0};
    steps[2] = '{"bounce_press2",  16'h0080, 2, 0, 4'd9,  1'b0};
    steps[3] = '{"bounce_release", 16'h0000, 2, 0, 4'd9,  1'b0};
    steps[4] = '{"multi_key",      16'h4020, 4, 1, 4'd5,  1'b1};
    steps[5] = '{"release_lowest", 16'h4000, 3, 0, 4'd5,  1'b0};
    steps[6] = '{"remaining_key",  16'h4000, 4, 1, 4'd14, 1'b1};

    tests_run    = 0;
    tests_failed = 0;
    pulses       = 0;
    prev_valid   = 1'b0;
    keys         = '0;
    rst          = 1'b1;
    enable       = 1'b0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_row", int'(keypadRow), 15);
      check("rst_valid", int'(key_valid), 0);
      check("rst_held", int'(key_held), 0);
      check("rst_code", int'(key_code), 0);
    end
    rst    = 1'b0;
    enable = 1'b1;
    tick();

    // Idle scan pattern over 10 frames.
    for (int i = 0; i < 160; i++) begin
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      check($sformatf("scan_row_c%0d", i), int'(keypadRow), int'(exp_row));
      check("scan_held", int'(key_held), 0);
      tick();
    end
    check("scan_no_pulses", pulses, 0);
    $display("[TB] idle scan: 10 frames checked, pulses=%0d", pulses);

    // Single press (2,1): accept latency and release timing.
    keys = 16'h0200;
    p0   = pulses;
    repeat (47) tick();
    check("press_pre_valid", int'(key_valid), 0);
    tick();
    check("press_valid", int'(key_valid), 1);
    check("press_code", int'(key_code), 9);
    check("press_held", int'(key_held), 1);
    tick();
    check("press_valid_drop", int'(key_valid), 0);
    repeat (47) tick();
    keys = '0;
    check("press_held_6f", int'(key_held), 1);
    repeat (47) tick();
    check("release_held_last", int'(key_held), 1);
    tick();
    check("release_held_clear", int'(key_held), 0);
    check("press_pulse_count", pulses - p0, 1);
    $display("[TB] press (2,1): pulses=%0d code=%0d held=%0d", pulses - p0, key_code, key_held);

    // Frame-aligned table of key patterns.
    for (int s = 0; s < 7; s++) begin
      keys = steps[s].keys;
      p0   = pulses;
      repeat (steps[s].frames * 16) tick();
      check({steps[s].name, "_pulses"}, pulses - p0, steps[s].exp_pulses);
      check({steps[s].name, "_code"}, int'(key_code), int'(steps[s].exp_code));
      check({steps[s].name, "_held"}, int'(key_held), int'(steps[s].exp_held));
      $display("[TB] step %s: keys=%h pulses=%0d code=%0d held=%0d",
               steps[s].name, steps[s].keys, pulses - p0, key_code, key_held);
    end

    // Disable while HELD, then re-enable with the key still down.
    repeat (5) tick();
    enable = 1'b0;
    tick();
    check("dis_row", int'(keypadRow), 15);
    check("dis_held", int'(key_held), 0);
    check("dis_valid", int'(key_valid), 0);
    check("dis_code_kept", int'(key_code), 14);
    tick();
    tick();
    enable = 1'b1;
    p0     = pulses;
    tick();
    check("reen_row", int'(keypadRow), 14);
    repeat (47) tick();
    check("reen_pre_valid", int'(key_valid), 0);
    tick();
    check("reen_valid", int'(key_valid), 1);
    check("reen_code", int'(key_code), 14);
    keys = '0;
    repeat (48) tick();
    check("reen_release_held", int'(key_held), 0);
    check("reen_pulse_count", pulses - p0, 1);
    $display("[TB] enable toggle: pulses=%0d code=%0d held=%0d", pulses - p0, key_code, key_held);

    // Reset during PRESS_CHK with cnt=2.
    keys = 16'h0001;
    p0   = pulses;
    repeat (39) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_row", int'(keypadRow), 15);
    check("rst_mid_valid", int'(key_valid), 0);
    check("rst_mid_held", int'(key_held), 0);
    check("rst_mid_code", int'(key_code), 0);
    check("rst_mid_no_pulse", pulses - p0, 0);
    rst = 1'b0;
    p0  = pulses;
    tick();
    check("rst_restart_row", int'(keypadRow), 14);
    repeat (47) tick();
    check("rst_restart_no_pulse", pulses - p0, 0);
    tick();
    check("rst_restart_valid", int'(key_valid), 1);
    check("rst_restart_code", int'(key_code), 0);
    $display("[TB] reset in PRESS_CHK: pulses after restart=%0d code=%0d", pulses - p0, key_code);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
